// File: rtl/jtag_tap_datapath.sv
// JTAG TAP datapath: instruction register chain, BYPASS/IDCODE/USER data
// registers and the serial TDO mux. Consumes the 4-bit TAP state from the
// upstream TAP controller; all state changes on posedge TCK.
//
// Ports:
//   TCK      - test clock
//   TRST     - synchronous active-high reset
//   STATE    - current TAP controller state
//   TDI      - serial data in
//   user_in  - parallel value captured into the USER DR on CAP_DR
//   TDO      - serial data out (0 outside the shift states)
//   TDO_EN   - high in SHIFT_DR / SHIFT_IR
//   IR       - active instruction
//   user_out - USER DR update latch
//   user_upd - one-cycle pulse after a USER update
module jtag_tap_datapath #(
    parameter int unsigned     IR_W       = 4,
    parameter int unsigned     USER_W     = 8,
    parameter logic [31:0]     IDCODE_VAL = 32'h1234_5677,
    parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(4'b0001),
    parameter logic [IR_W-1:0] OP_USER    = IR_W'(4'b0010)
) (
    input  logic              TCK,
    input  logic              TRST,
    input  logic [3:0]        STATE,
    input  logic              TDI,
    input  logic [USER_W-1:0] user_in,
    output logic              TDO,
    output logic              TDO_EN,
    output logic [IR_W-1:0]   IR,
    output logic [USER_W-1:0] user_out,
    output logic              user_upd
);

    typedef enum logic [3:0] {
        StTlr     = 4'h0,
        StRti     = 4'h1,
        StSelDr   = 4'h2,
        StCapDr   = 4'h3,
        StShiftDr = 4'h4,
        StExit1Dr = 4'h5,
        StPauseDr = 4'h6,
        StExit2Dr = 4'h7,
        StUpdDr   = 4'h8,
        StSelIr   = 4'h9,
        StCapIr   = 4'hA,
        StShiftIr = 4'hB,
        StExit1Ir = 4'hC,
        StPauseIr = 4'hD,
        StExit2Ir = 4'hE,
        StUpdIr   = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        SelBypass,
        SelIdcode,
        SelUser
    } dr_sel_e;

    tap_state_e tap_st;
    dr_sel_e    dr_sel;

    logic [IR_W-1:0]   ir_q, ir_d;
    logic [IR_W-1:0]   ir_sr_q, ir_sr_d;
    logic              bypass_sr_q, bypass_sr_d;
    logic [31:0]       idcode_sr_q, idcode_sr_d;
    logic [USER_W-1:0] user_sr_q, user_sr_d;
    logic [USER_W-1:0] user_out_q, user_out_d;
    logic              user_upd_q, user_upd_d;

    assign tap_st = tap_state_e'(STATE);

    // Undefined opcodes (including all-ones) fall through to BYPASS.
    always_comb begin
        dr_sel = SelBypass;
        if (ir_q == OP_IDCODE) begin
            dr_sel = SelIdcode;
        end else if (ir_q == OP_USER) begin
            dr_sel = SelUser;
        end
    end

    always_comb begin
        ir_d        = ir_q;
        ir_sr_d     = ir_sr_q;
        bypass_sr_d = bypass_sr_q;
        idcode_sr_d = idcode_sr_q;
        user_sr_d   = user_sr_q;
        user_out_d  = user_out_q;
        user_upd_d  = 1'b0;

        case (tap_st)
            StTlr: begin
                ir_d = OP_IDCODE;
            end
            StCapIr: begin
                ir_sr_d      = '0;
                ir_sr_d[1:0] = 2'b01;
            end
            StShiftIr: begin
                ir_sr_d = {TDI, ir_sr_q[IR_W-1:1]};
            end
            StUpdIr: begin
                ir_d = ir_sr_q;
            end
            StCapDr: begin
                case (dr_sel)
                    SelIdcode: idcode_sr_d = IDCODE_VAL;
                    SelUser:   user_sr_d   = user_in;
                    default:   bypass_sr_d = 1'b0;
                endcase
            end
            StShiftDr: begin
                case (dr_sel)
                    SelIdcode: idcode_sr_d = {TDI, idcode_sr_q[31:1]};
                    SelUser:   user_sr_d   = {TDI, user_sr_q[USER_W-1:1]};
                    default:   bypass_sr_d = TDI;
                endcase
            end
            StUpdDr: begin
                if (dr_sel == SelUser) begin
                    user_out_d = user_sr_q;
                    user_upd_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_q        <= OP_IDCODE;
            ir_sr_q     <= '0;
            bypass_sr_q <= 1'b0;
            idcode_sr_q <= '0;
            user_sr_q   <= '0;
            user_out_q  <= '0;
            user_upd_q  <= 1'b0;
        end else begin
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            bypass_sr_q <= bypass_sr_d;
            idcode_sr_q <= idcode_sr_d;
            user_sr_q   <= user_sr_d;
            user_out_q  <= user_out_d;
            user_upd_q  <= user_upd_d;
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (tap_st == StShiftIr) begin
            TDO = ir_sr_q[0];
        end else if (tap_st == StShiftDr) begin
            case (dr_sel)
                SelIdcode: TDO = idcode_sr_q[0];
                SelUser:   TDO = user_sr_q[0];
                default:   TDO = bypass_sr_q;
            endcase
        end
    end

    assign TDO_EN   = (tap_st == StShiftDr) || (tap_st == StShiftIr);
    assign IR       = ir_q;
    assign user_out = user_out_q;
    assign user_upd = user_upd_q;

endmodule
